// File: rtl/piso_ser.sv
// Parametrised parallel-in/serial-out serializer with valid/ready load,
// shift-enable pacing, last-bit flag and gapless back-to-back words.
// Ports: clk, clr (async active-low), d[WIDTH], load_valid, load_ready,
//        shift_en, q, q_valid, done, busy.
module piso_ser #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             q,
  output logic             q_valid,
  output logic             done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_q;
  logic             w_q_nxt;
  logic             r_q_valid;
  logic             w_q_valid_nxt;
  logic             r_done;
  logic             w_done_nxt;

  logic             w_last;
  logic             w_load;
  logic             w_out_bit;
  logic [WIDTH-1:0] w_shifted;

  // Final bit leaves this edge; the slot frees up for a gapless reload.
  assign w_last = (r_state == S_SHIFT) && (r_cnt == CNT_ONE) && shift_en;

  assign load_ready = clr && ((r_state == S_IDLE) || w_last);
  assign w_load     = load_valid && load_ready;

  assign w_out_bit = (MSB_FIRST != 0) ? r_shreg[WIDTH-1] : r_shreg[0];
  assign w_shifted = (MSB_FIRST != 0) ? (r_shreg << 1) : (r_shreg >> 1);

  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_cnt_nxt     = r_cnt;
    w_q_nxt       = r_q;
    w_q_valid_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_shreg_nxt = d;
          w_cnt_nxt   = CNT_FULL;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (shift_en) begin
          w_q_nxt       = w_out_bit;
          w_shreg_nxt   = w_shifted;
          w_cnt_nxt     = r_cnt - CNT_ONE;
          w_q_valid_nxt = 1'b1;
          if (w_last) begin
            w_done_nxt = 1'b1;
            if (w_load) begin
              w_shreg_nxt = d;
              w_cnt_nxt   = CNT_FULL;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_cnt     <= '0;
      r_q       <= 1'b0;
      r_q_valid <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_cnt     <= w_cnt_nxt;
      r_q       <= w_q_nxt;
      r_q_valid <= w_q_valid_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign done    = r_done;
  assign busy    = (r_state == S_SHIFT);

endmodule

// File: tb/tb_piso_ser.sv
// Testbench for piso_ser: LSB-first and MSB-first instances driven in
// parallel, checked every cycle against a bit-queue model.
module tb_piso_ser;

  localparam int W = 8;

  logic         clk;
  logic         clr;
  logic [W-1:0] d;
  logic         load_valid;
  logic         shift_en;

  logic         rdy_a[2];
  logic         q_a[2];
  logic         qv_a[2];
  logic         dn_a[2];
  logic         bz_a[2];

  int errs;
  int checks;

  // model: pending bits in emission order, next bit at index 0
  logic [W-1:0] pend[2];
  int           pcnt[2];
  logic         eq[2];
  logic         ev[2];
  logic         ed[2];

  // observed history per instance
  logic [15:0]  hist[2];
  int           vcnt[2];
  int           dcnt[2];

  piso_ser #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .clr(clr), .d(d), .load_valid(load_valid),
    .load_ready(rdy_a[0]), .shift_en(shift_en), .q(q_a[0]),
    .q_valid(qv_a[0]), .done(dn_a[0]), .busy(bz_a[0])
  );

  piso_ser #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk(clk), .clr(clr), .d(d), .load_valid(load_valid),
    .load_ready(rdy_a[1]), .shift_en(shift_en), .q(q_a[1]),
    .q_valid(qv_a[1]), .done(dn_a[1]), .busy(bz_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t",
               nm, i, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int k = 0; k < W; k++) r[k] = w[W-1-k];
    return r;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!clr) begin
        chk("rst_q", i, 32'(q_a[i]), 0);
        chk("rst_qv", i, 32'(qv_a[i]), 0);
        chk("rst_done", i, 32'(dn_a[i]), 0);
        chk("rst_busy", i, 32'(bz_a[i]), 0);
        chk("rst_ready", i, 32'(rdy_a[i]), 0);
        pcnt[i] = 0;
        pend[i] = '0;
        eq[i] = 1'b0;
        ev[i] = 1'b0;
        ed[i] = 1'b0;
      end else begin
        logic rdy;
        logic v;
        chk("q", i, 32'(q_a[i]), 32'(eq[i]));
        chk("q_valid", i, 32'(qv_a[i]), 32'(ev[i]));
        chk("done", i, 32'(dn_a[i]), 32'(ed[i]));
        chk("busy", i, 32'(bz_a[i]), 32'(pcnt[i] > 0));
        rdy = (pcnt[i] == 0) || (pcnt[i] == 1 && shift_en);
        chk("load_ready", i, 32'(rdy_a[i]), 32'(rdy));
        if (qv_a[i]) begin
          hist[i] = {hist[i][14:0], q_a[i]};
          vcnt[i]++;
        end
        if (dn_a[i]) dcnt[i]++;
        v = shift_en && (pcnt[i] > 0);
        ed[i] = v && (pcnt[i] == 1);
        ev[i] = v;
        if (v) begin
          eq[i] = pend[i][0];
          pend[i] = pend[i] >> 1;
          pcnt[i]--;
        end
        if (rdy && load_valid) begin
          pend[i] = (i == 1) ? rev(d) : d;
          pcnt[i] = W;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    for (int i = 0; i < 2; i++) begin
      hist[i] = '0;
      vcnt[i] = 0;
      dcnt[i] = 0;
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    for (int i = 0; i < 2; i++) begin
      pcnt[i] = 0;
      pend[i] = '0;
      eq[i] = 1'b0;
      ev[i] = 1'b0;
      ed[i] = 1'b0;
    end
    clr_stats();
    clr = 1'b0;
    d = '0;
    load_valid = 1'b0;
    shift_en = 1'b0;

    // reset and release
    step(3);
    chk("lit_ready_in_rst", 0, 32'(rdy_a[0]), 0);
    clr = 1'b1;
    #1;
    chk("lit_ready_after_rst", 0, 32'(rdy_a[0]), 1);
    chk("lit_ready_after_rst", 1, 32'(rdy_a[1]), 1);
    step(1);

    // 0xA5, continuous shift
    clr_stats();
    d = 8'hA5;
    load_valid = 1'b1;
    shift_en = 1'b1;
    step(1);
    load_valid = 1'b0;
    step(8);
    shift_en = 1'b0;
    step(2);
    chk("lit_a5_seq", 0, 32'(hist[0][7:0]), 32'hA5);
    chk("lit_a5_seq", 1, 32'(hist[1][7:0]), 32'hA5);
    chk("lit_a5_done", 0, 32'(dcnt[0]), 1);
    chk("lit_a5_vcnt", 1, 32'(vcnt[1]), 8);
    chk("lit_a5_busy", 0, 32'(bz_a[0]), 0);
    chk("lit_a5_ready", 0, 32'(rdy_a[0]), 1);

    // 0x3C with stalls
    begin
      logic [15:0] pat;
      pat = 16'b1011_0101_1011_0111;
      clr_stats();
      d = 8'h3C;
      load_valid = 1'b1;
      step(1);
      load_valid = 1'b0;
      for (int k = 15; k >= 0; k--) begin
        shift_en = pat[k];
        step(1);
      end
      shift_en = 1'b0;
      step(2);
    end
    chk("lit_3c_seq", 0, 32'(hist[0][7:0]), 32'h3C);
    chk("lit_3c_seq", 1, 32'(hist[1][7:0]), 32'h3C);
    chk("lit_3c_done", 0, 32'(dcnt[0]), 1);
    chk("lit_3c_done", 1, 32'(dcnt[1]), 1);

    // gapless 0xFF then 0x00
    clr_stats();
    d = 8'hFF;
    load_valid = 1'b1;
    shift_en = 1'b1;
    step(1);
    d = 8'h00;
    step(8);
    load_valid = 1'b0;
    step(8);
    shift_en = 1'b0;
    step(2);
    chk("lit_gap_seq", 0, 32'(hist[0]), 32'hFF00);
    chk("lit_gap_seq", 1, 32'(hist[1]), 32'hFF00);
    chk("lit_gap_vcnt", 0, 32'(vcnt[0]), 16);
    chk("lit_gap_done", 0, 32'(dcnt[0]), 2);

    // offer 0x55 while busy, then again when idle
    clr_stats();
    d = 8'h0F;
    load_valid = 1'b1;
    shift_en = 1'b1;
    step(1);
    d = 8'h55;
    step(3);
    load_valid = 1'b0;
    step(7);
    chk("lit_ign_mid", 0, 32'(hist[0][7:0]), 32'hF0);
    chk("lit_ign_mid", 1, 32'(hist[1][7:0]), 32'h0F);
    load_valid = 1'b1;
    step(1);
    load_valid = 1'b0;
    step(8);
    shift_en = 1'b0;
    step(2);
    chk("lit_ign_seq", 0, 32'(hist[0]), 32'hF0AA);
    chk("lit_ign_seq", 1, 32'(hist[1]), 32'h0F55);
    chk("lit_ign_done", 1, 32'(dcnt[1]), 2);

    // asynchronous reset mid-word
    d = 8'hA5;
    load_valid = 1'b1;
    shift_en = 1'b1;
    step(1);
    load_valid = 1'b0;
    step(3);
    chk("lit_pre_rst_busy", 0, 32'(bz_a[0]), 1);
    clr = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("lit_arst_q", i, 32'(q_a[i]), 0);
      chk("lit_arst_qv", i, 32'(qv_a[i]), 0);
      chk("lit_arst_done", i, 32'(dn_a[i]), 0);
      chk("lit_arst_busy", i, 32'(bz_a[i]), 0);
      chk("lit_arst_ready", i, 32'(rdy_a[i]), 0);
    end
    step(2);
    clr = 1'b1;
    clr_stats();
    step(12);
    chk("lit_abort_vcnt", 0, 32'(vcnt[0]), 0);
    chk("lit_abort_done", 1, 32'(dcnt[1]), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/piso_ser.md
Name: piso_ser

Overview:
Parametrised parallel-in/serial-out serializer, successor to the team's fixed 4-bit PISO. Loads a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per enabled clock, LSB- or MSB-first. Paces output with a shift-enable and flags the final bit. Supports gapless back-to-back words. Sits between a parallel datapath and a serial link or bit-banged interface.

Parameters:
WIDTH, 8, word width in bits; legal range 2..64.
MSB_FIRST, 0, 0 = shift LSB first, 1 = shift MSB first.
Derived: CNT_W = $clog2(WIDTH+1), width of the internal bit counter.

Ports:
clk  input  1  clock; all state updates on its rising edge.
clr  input  1  asynchronous, active-low reset; clears the block while low.
d  input  WIDTH  parallel word to load.
load_valid  input  1  d is valid and offered for load.
load_ready  output  1  block accepts d this cycle. Combinational.
shift_en  input  1  advance one bit this cycle; otherwise hold.
q  output  1  serial data bit. Registered.
q_valid  output  1  q carries a fresh bit this cycle. Registered.
done  output  1  one-cycle pulse coinciding with the last bit of a word on q. Registered.
busy  output  1  a word is loaded and not yet fully shifted (state SHIFT).

Behaviour:
- Reset (clr low, asynchronous):
  - shreg = 0, cnt = 0, state = IDLE.
  - q = 0, q_valid = 0, done = 0, busy = 0.
  - load_ready is forced to 0 while clr is low.
  - Reset mid-word aborts the word: no done pulse, and no remaining bits are emitted.
- State IDLE:
  - load_ready = 1.
  - load_valid = 1 at an edge: shreg <= d, cnt <= WIDTH, state <= SHIFT. q_valid <= 0 on that edge.
  - shift_en is ignored in IDLE.
- State SHIFT, on an edge with shift_en = 1:
  - q <= shreg[0] if MSB_FIRST = 0, else shreg[WIDTH-1].
  - shreg shifts toward the output end; the vacated bit fills with 0.
  - cnt <= cnt-1, q_valid <= 1.
- State SHIFT, on an edge with shift_en = 0:
  - q, shreg and cnt hold. q_valid <= 0, done <= 0.
- Last bit: an edge in SHIFT with cnt == 1 and shift_en = 1.
  - Emits the final bit and sets done <= 1 for exactly one cycle, alongside q_valid = 1.
  - If no load is accepted on that edge, state <= IDLE.
- Gapless reload: load_ready = 1 in SHIFT only when cnt == 1 && shift_en == 1.
  - If load_valid = 1 on that edge, the final bit of the old word is emitted and shreg <= d, cnt <= WIDTH in the same edge. State stays SHIFT.
  - The next word's first bit is emitted on the following enabled edge, with no idle cycle.
- load_valid while load_ready = 0 is ignored, and d is not sampled.
- Latency: load accepted at edge N → first bit valid after edge N+1 if shift_en is high there. Without stalls, a word occupies WIDTH consecutive q_valid cycles.
- q holds its last value after a word completes. q_valid = 0 in IDLE after the done cycle.
- busy = (state == SHIFT). It is combinational from the state register.
- cnt never underflows: cnt == 0 only in IDLE.

Test Plan:
1. Reset: clr low mid-shift, WIDTH=8 → q=0, q_valid=0, done=0, busy=0 immediately (asynchronous). load_ready=0 while clr is low and 1 after release.
2. LSB-first: WIDTH=8, MSB_FIRST=0, load 0xA5, shift_en held 1 → q = 1,0,1,0,0,1,0,1 on 8 consecutive q_valid cycles. done is high only with the 8th bit; then busy=0 and load_ready=1.
3. MSB-first: WIDTH=8, MSB_FIRST=1, load 0xA5 → q = 1,0,1,0,0,1,0,1 (MSB order), with done on the 8th bit.
4. Stall: load 0x3C, toggle shift_en 1,0,1,1,0,... → q_valid=0 and q holds on every shift_en=0 cycle. The bit sequence is still 0,0,1,1,1,1,0,0 (LSB first), and done fires once.
5. Gapless: load 0xFF, hold load_valid=1 with d=0x00 offered, shift_en=1 → load_ready pulses on the 8th-bit edge only. The output is 8 ones followed immediately by 8 zeros over 16 consecutive q_valid cycles, with two done pulses spaced 8 cycles apart.
6. Ignored load: load_valid=1 with d=0x55 while busy and cnt>1 → the word in flight is unaffected, and 0x55 is not shifted until it is offered when load_ready=1.
